// File: rtl/prng256_mixer_if.sv
// rtl/prng256_mixer_if.sv - generator-pair input and tempered-word output handshake bundle
interface prng256_mixer_if;
  logic         in_valid;
  logic [127:0] in_a;
  logic [127:0] in_b;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/prng256_mixer.sv
// rtl/prng256_mixer.sv - tempers LCG word pairs into 256-bit words, FWFT FIFO, repetition health test
module prng256_mixer #(
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  prng256_mixer_if.slave      bus,
  output logic                health_fail,
  input  logic                clear_fail,
  output logic [15:0]         drop_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(REP_LIMIT + 1);

  typedef enum logic {ST_RUN, ST_FAIL} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [RW-1:0]  rep_cnt_q, rep_cnt_d;
  logic [255:0]   prev_word_q, prev_word_d;
  logic           prev_valid_q, prev_valid_d;
  logic           health_fail_q, health_fail_d;
  logic [15:0]    drop_q, drop_d;
  logic [255:0]   mem_q [DEPTH];

  logic [127:0]   ta, tb;
  logic [255:0]   word;
  logic           in_ready_c, out_valid_c;
  logic           accept, pop, push, match, trip;
  logic [RW-1:0]  rep_next;

  // Both tempering terms deliberately use the raw inputs, not each other.
  assign ta   = bus.in_a ^ {bus.in_b[66:0], bus.in_b[127:67]};
  assign tb   = bus.in_b ^ {bus.in_a[28:0], bus.in_a[127:29]};
  assign word = {ta, tb};

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    rep_cnt_d     = rep_cnt_q;
    prev_word_d   = prev_word_q;
    prev_valid_d  = prev_valid_q;
    health_fail_d = health_fail_q;
    drop_d        = drop_q;

    in_ready_c  = !rst && (state_q == ST_RUN) && (count_q < CW'(DEPTH));
    out_valid_c = (state_q == ST_RUN) && (count_q != '0);
    accept      = bus.in_valid && in_ready_c;
    pop         = out_valid_c && bus.out_ready;
    match       = prev_valid_q && (word == prev_word_q);
    rep_next    = match ? (rep_cnt_q + RW'(1)) : RW'(1);
    trip        = accept && (rep_next == RW'(REP_LIMIT));
    push        = accept && !trip;

    if (bus.in_valid && !in_ready_c && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          rep_cnt_d    = rep_next;
          prev_word_d  = word;
          prev_valid_d = 1'b1;
        end
        // The failing word is dropped and the buffered words are discarded with it.
        if (trip) begin
          state_d       = ST_FAIL;
          health_fail_d = 1'b1;
          count_d       = '0;
          rd_ptr_d      = '0;
          wr_ptr_d      = '0;
        end else begin
          if (push) wr_ptr_d = wr_ptr_q + PW'(1);
          if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
          if (push && !pop)      count_d = count_q + CW'(1);
          else if (!push && pop) count_d = count_q - CW'(1);
        end
      end
      ST_FAIL: begin
        if (clear_fail) begin
          state_d       = ST_RUN;
          health_fail_d = 1'b0;
          rep_cnt_d     = '0;
          prev_valid_d  = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      rep_cnt_q     <= '0;
      prev_word_q   <= '0;
      prev_valid_q  <= 1'b0;
      health_fail_q <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      rep_cnt_q     <= rep_cnt_d;
      prev_word_q   <= prev_word_d;
      prev_valid_q  <= prev_valid_d;
      health_fail_q <= health_fail_d;
      drop_q        <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_valid_c ? mem_q[rd_ptr_q] : '0;
  assign health_fail   = health_fail_q;
  assign drop_count    = drop_q;
endmodule
